// File: rtl/vip_fb_swap_sequencer.sv
// Triple-buffer scheduler for the CVO frame-buffer path: tracks display/pending/write
// buffers, programs the frame reader over Avalon-MM on v_sync and counts underflow cycles.
module vip_fb_swap_sequencer #(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] FB_BASE     = ADDR_W'(32'h3000_0000),
    parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h0012_C000),
    parameter logic [ADDR_W-1:0] CSR_CTRL    = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] CSR_FADDR   = ADDR_W'(32'h0000_0010)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              vid_v_sync,
    input  logic              underflow,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic              init_done,
    output logic [15:0]       underflow_cnt,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {S_INIT_ADDR, S_INIT_GO, S_IDLE, S_SWAP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        disp, pend, wr, tgt;
    logic [1:0]        disp_nxt, pend_nxt, wr_nxt, tgt_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic              wr_done_q, wr_done_q_nxt;
    logic              vsync_q;
    logic              init_done_nxt;
    logic              avm_write_nxt;
    logic [ADDR_W-1:0] avm_address_nxt, rd_base_nxt;
    logic [31:0]       avm_writedata_nxt;
    logic              accept, vs_edge;

    function automatic logic [ADDR_W-1:0] buf_base(input logic [1:0] n);
        return FB_BASE + ADDR_W'(n) * FRAME_BYTES;
    endfunction

    assign accept  = avm_write & ~avm_waitrequest;
    assign vs_edge = vid_v_sync & ~vsync_q;

    // NOTE: every *_nxt gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt         = state;
        disp_nxt          = disp;
        pend_nxt          = pend;
        wr_nxt            = wr;
        tgt_nxt           = tgt;
        pend_valid_nxt    = pend_valid;
        wr_done_q_nxt     = wr_done_q | wr_done;
        init_done_nxt     = init_done;
        avm_write_nxt     = avm_write;
        avm_address_nxt   = avm_address;
        avm_writedata_nxt = avm_writedata;
        rd_base_nxt       = rd_base;

        unique case (state)
            S_INIT_ADDR: begin
                if (!avm_write) begin
                    avm_write_nxt     = 1'b1;
                    avm_address_nxt   = CSR_FADDR;
                    avm_writedata_nxt = 32'(buf_base(disp));
                end else if (accept) begin
                    avm_write_nxt = 1'b0;
                    state_nxt     = S_INIT_GO;
                end
            end
            S_INIT_GO: begin
                if (!avm_write) begin
                    avm_write_nxt     = 1'b1;
                    avm_address_nxt   = CSR_CTRL;
                    avm_writedata_nxt = 32'h1;
                end else if (accept) begin
                    avm_write_nxt = 1'b0;
                    init_done_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (vs_edge && pend_valid) begin
                    tgt_nxt   = pend;
                    state_nxt = S_SWAP;
                end else if (wr_done || wr_done_q) begin
                    // A still-pending frame is dropped and its buffer recycled for writing.
                    pend_nxt       = wr;
                    pend_valid_nxt = 1'b1;
                    wr_nxt         = pend_valid ? pend : 2'd3 - disp - wr;
                    wr_done_q_nxt  = 1'b0;
                end
            end
            S_SWAP: begin
                if (!avm_write) begin
                    avm_write_nxt     = 1'b1;
                    avm_address_nxt   = CSR_FADDR;
                    avm_writedata_nxt = 32'(buf_base(tgt));
                end else if (accept) begin
                    avm_write_nxt  = 1'b0;
                    disp_nxt       = tgt;
                    pend_valid_nxt = 1'b0;
                    rd_base_nxt    = buf_base(tgt);
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_INIT_ADDR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state         <= S_INIT_ADDR;
            disp          <= 2'd0;
            pend          <= 2'd2;
            wr            <= 2'd1;
            tgt           <= 2'd0;
            pend_valid    <= 1'b0;
            wr_done_q     <= 1'b0;
            vsync_q       <= 1'b0;
            init_done     <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            rd_base       <= FB_BASE;
            wr_base       <= FB_BASE + FRAME_BYTES;
            underflow_cnt <= '0;
        end else begin
            state         <= state_nxt;
            disp          <= disp_nxt;
            pend          <= pend_nxt;
            wr            <= wr_nxt;
            tgt           <= tgt_nxt;
            pend_valid    <= pend_valid_nxt;
            wr_done_q     <= wr_done_q_nxt;
            vsync_q       <= vid_v_sync;
            init_done     <= init_done_nxt;
            avm_write     <= avm_write_nxt;
            avm_address   <= avm_address_nxt;
            avm_writedata <= avm_writedata_nxt;
            rd_base       <= rd_base_nxt;
            // Follows the registered write index, so it lags an index update by one cycle.
            wr_base       <= buf_base(wr);
            if (underflow && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vip_fb_swap_sequencer.sv
// Directed bench for vip_fb_swap_sequencer: expected CSR writes are queued when stimulus
// is driven and compared by a bus monitor when the DUT's write is accepted.
module tb_vip_fb_swap_sequencer;

    localparam logic [31:0] FB_BASE     = 32'h3000_0000;
    localparam logic [31:0] FRAME_BYTES = 32'h0012_C000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        underflow = 1'b0;
    logic        wr_done = 1'b0;
    logic        waitreq = 1'b0;
    logic [31:0] wr_base, rd_base, avm_address, avm_writedata;
    logic        init_done, avm_write;
    logic [15:0] underflow_cnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vip_fb_swap_sequencer dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .vid_v_sync      (vsync),
        .underflow       (underflow),
        .wr_done         (wr_done),
        .wr_base         (wr_base),
        .rd_base         (rd_base),
        .init_done       (init_done),
        .underflow_cnt   (underflow_cnt),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (waitreq)
    );

    function automatic logic [31:0] base(input int n);
        return FB_BASE + 32'(n) * FRAME_BYTES;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic wait_write(input string tag);
        for (int i = 0; i < 20 && !avm_write; i++) tick();
        check(tag, 64'(avm_write), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic pulse_wr_done();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic do_reset_init(input string tag);
        rst = 1'b1;
        tick();
        push(32'h10, FB_BASE);
        push(32'h0, 32'h1);
        rst = 1'b0;
        wait_drain({tag, "_drain"});
        check({tag, "_init_done"}, 64'(init_done), 64'd1);
        check({tag, "_wr_base"}, 64'(wr_base), 64'(base(1)));
        check({tag, "_rd_base"}, 64'(rd_base), 64'(base(0)));
    endtask

    // Bus monitor: stability while stalled, and in-order compare on acceptance.
    logic        stall_seen = 1'b0;
    logic [31:0] stall_addr, stall_data;
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else if (avm_write) begin
            if (stall_seen) begin
                check("stall_addr_stable", 64'(avm_address), 64'(stall_addr));
                check("stall_data_stable", 64'(avm_writedata), 64'(stall_data));
            end
            if (!waitreq) begin
                stall_seen = 1'b0;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("avm_address", 64'(avm_address), 64'(w.addr));
                    check("avm_writedata", 64'(avm_writedata), 64'(w.data));
                end
            end else begin
                stall_seen = 1'b1;
                stall_addr = avm_address;
                stall_data = avm_writedata;
            end
        end
    end

    initial begin
        int nw;

        // Reset state
        tick();
        check("rst_avm_write", 64'(avm_write), 64'd0);
        check("rst_avm_address", 64'(avm_address), 64'd0);
        check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
        check("rst_rd_base", 64'(rd_base), 64'(32'h3000_0000));
        check("rst_wr_base", 64'(wr_base), 64'(32'h3012_C000));
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_underflow_cnt", 64'(underflow_cnt), 64'd0);

        // Init sequence
        do_reset_init("init1");

        // Single wr_done then v_sync swap, with latency check
        pulse_wr_done();
        tick();
        check("pend_wr_base", 64'(wr_base), 64'(32'h3025_8000));
        push(32'h10, 32'h3012_C000);
        vsync = 1'b1;
        tick();
        check("lat_cycle1_write", 64'(avm_write), 64'd0);
        tick();
        check("lat_cycle2_write", 64'(avm_write), 64'd1);
        wait_drain("swap1_drain");
        vsync = 1'b0;
        check("swap1_rd_base", 64'(rd_base), 64'(32'h3012_C000));
        check("swap1_wr_base", 64'(wr_base), 64'(32'h3025_8000));

        // Two wr_done pulses before v_sync recycle the dropped pending buffer
        do_reset_init("init2");
        pulse_wr_done();
        tick();
        check("dbl_wr_base1", 64'(wr_base), 64'(32'h3025_8000));
        pulse_wr_done();
        tick();
        check("dbl_wr_base2", 64'(wr_base), 64'(32'h3012_C000));
        push(32'h10, 32'h3025_8000);
        vsync = 1'b1;
        wait_drain("swap2_drain");
        vsync = 1'b0;
        check("swap2_rd_base", 64'(rd_base), 64'(32'h3025_8000));
        check("swap2_wr_base", 64'(wr_base), 64'(32'h3012_C000));

        // Stalled swap with wr_done mid-stall: disp=2,wr=1 -> pend=1, wr=0
        pulse_wr_done();
        tick();
        check("stall_pre_wr_base", 64'(wr_base), 64'(32'h3000_0000));
        waitreq = 1'b1;
        push(32'h10, 32'h3012_C000);
        vsync = 1'b1;
        wait_write("stall_write_seen");
        vsync = 1'b0;
        tick();
        tick();
        pulse_wr_done();
        tick();
        tick();
        check("stall_write_held", 64'(avm_write), 64'd1);
        check("stall_deferred_wr_base", 64'(wr_base), 64'(32'h3000_0000));
        waitreq = 1'b0;
        wait_drain("stall_drain");
        check("stall_rd_base", 64'(rd_base), 64'(32'h3012_C000));
        check("stall_applied_wr_base", 64'(wr_base), 64'(32'h3025_8000));

        // Consume the pending frame (buffer 0) so nothing is pending
        push(32'h10, 32'h3000_0000);
        vsync = 1'b1;
        wait_drain("swap3_drain");
        vsync = 1'b0;
        check("swap3_rd_base", 64'(rd_base), 64'(32'h3000_0000));

        // v_sync edge with nothing pending issues no write
        tick();
        vsync = 1'b1;
        nw = 0;
        repeat (6) begin
            tick();
            if (avm_write) nw++;
        end
        vsync = 1'b0;
        check("no_pending_no_write", 64'(nw), 64'd0);

        // Underflow counter saturation
        underflow = 1'b1;
        repeat (3) tick();
        check("uf_cnt_3", 64'(underflow_cnt), 64'd3);
        repeat (65531) tick();
        check("uf_cnt_fffe", 64'(underflow_cnt), 64'hFFFE);
        tick();
        check("uf_cnt_ffff", 64'(underflow_cnt), 64'hFFFF);
        repeat (4465) tick();
        underflow = 1'b0;
        check("uf_cnt_sat", 64'(underflow_cnt), 64'hFFFF);

        // Reset during a stalled swap write: disp=0,wr=2 -> pend=2 -> swap to buffer 2
        pulse_wr_done();
        waitreq = 1'b1;
        push(32'h10, 32'h3025_8000);
        vsync = 1'b1;
        wait_write("rst_mid_write_seen");
        vsync = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_avm_write", 64'(avm_write), 64'd0);
        check("rst_mid_init_done", 64'(init_done), 64'd0);
        check("rst_mid_underflow_cnt", 64'(underflow_cnt), 64'd0);
        exp_q.delete();
        waitreq = 1'b0;
        do_reset_init("init3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vip_fb_swap_sequencer.md
Name: vip_fb_swap_sequencer

Overview:
Triple-buffer scheduler for the video frame-buffer path feeding the clocked video output (CVO). It holds the display, pending and write buffer indices. It tells the pixel producer where to write. At each rising edge of v_sync it programs the frame reader's base-address CSR over an Avalon-MM master. It also counts CVO underflow cycles for software.

Parameters:
ADDR_W, 32, Avalon-MM master address width (byte addressing)
FB_BASE, 32'h3000_0000, DDR3 byte address of buffer 0
FRAME_BYTES, 32'h0012_C000, bytes per buffer (640x480x4); buffer n base = FB_BASE + n*FRAME_BYTES, mod 2^ADDR_W
CSR_CTRL, 32'h0000_0000, reader control register address; bit0 = Go
CSR_FADDR, 32'h0000_0010, reader frame base-address register address

Ports:
clk_clk  in  1  clock; all logic on rising edge
reset_reset  in  1  asynchronous, active-high reset
vid_v_sync  in  1  CVO v_sync, same clock domain; active high
underflow  in  1  CVO underflow flag
wr_done  in  1  single-cycle pulse: producer finished the frame at wr_base
wr_base  out  ADDR_W  base address the producer must write into next
rd_base  out  ADDR_W  base address of the buffer currently being displayed
init_done  out  1  high once the reader has been programmed and started
underflow_cnt  out  16  saturating count of cycles with underflow=1
avm_address  out  ADDR_W  CSR master address
avm_write  out  1  CSR write strobe
avm_writedata  out  32  CSR write data
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: disp=0, wr=1, pend_valid=0, wr_done_q=0, vsync_q=0. avm_write=0, avm_address=0, avm_writedata=0. rd_base=FB_BASE, wr_base=FB_BASE+FRAME_BYTES. init_done=0, underflow_cnt=0, state=S_INIT_ADDR.
- Indices are 2-bit values in 0..2. With pend_valid=1, {disp,pend,wr} are a permutation of {0,1,2}. The free index is 3-disp-wr.
- Avalon rule: address, writedata and write are registered. Once avm_write is asserted it stays high with address and data stable until a cycle with avm_waitrequest=0. That cycle is the acceptance; avm_write drops the next cycle. No reads are issued.
- FSM:
  - S_INIT_ADDR: write FB_BASE+disp*FRAME_BYTES to CSR_FADDR. On acceptance go to S_INIT_GO.
  - S_INIT_GO: write 32'h1 to CSR_CTRL. On acceptance set init_done=1 and go to S_IDLE.
  - S_IDLE: on a v_sync rising edge (vid_v_sync & ~vsync_q) with pend_valid=1, latch tgt=pend and go to S_SWAP. Otherwise, if wr_done or wr_done_q is set, apply the wr_done update (below) and clear wr_done_q.
  - S_SWAP: write FB_BASE+tgt*FRAME_BYTES to CSR_FADDR. On acceptance set disp=tgt, pend_valid=0, rd_base=new address, and go to S_IDLE.
- wr_done update:
  - pend=wr and pend_valid=1.
  - New wr = old pend if pend_valid was 1 (the old pending frame is dropped). Otherwise new wr = 3-disp-wr.
  - wr_base updates the cycle after the update.
- wr_done outside S_IDLE, or in the same cycle as a swap-triggering v_sync edge, sets wr_done_q. It is applied on the first S_IDLE cycle; multiple deferred pulses merge into one.
- v_sync edges outside S_IDLE, or with pend_valid=0, are ignored. Edges in the init states are ignored.
- underflow_cnt increments each cycle underflow=1 and saturates at 16'hFFFF. It is active in all states.
- Reset asserted mid-transaction drops avm_write immediately (asynchronous) and restarts the init sequence.
- Latency: v_sync edge to first avm_write high = 2 cycles (edge-detect register, then FSM register) with avm_waitrequest=0.

Test Plan:
- Reset, waitrequest=0 -> writes 0x3000_0000 to 0x10, then 0x1 to 0x0; init_done=1; wr_base=0x3012_C000.
- wr_done pulse, then v_sync rising edge -> write 0x3012_C000 to 0x10. Afterwards rd_base=0x3012_C000 and wr_base=0x3025_8000 (unchanged, because it was already set by the wr_done that created the pending frame). Before the swap, wr_base must equal 0x3025_8000 and never a displayed buffer.
- Two wr_done pulses before any v_sync -> second pulse recycles the dropped pending buffer. wr_base goes 0x3012_C000 -> 0x3025_8000 -> 0x3012_C000; the next swap displays buffer 2 (0x3025_8000).
- avm_waitrequest held high 5 cycles during S_SWAP with wr_done mid-stall -> avm_write, address and data stable throughout. The wr_done is deferred and applied on the first S_IDLE cycle with the new disp.
- v_sync edge with pend_valid=0 -> no avm_write. underflow high 70000 cycles -> underflow_cnt=0xFFFF.
- Reset asserted while avm_write=1 -> avm_write=0 immediately; after release the init writes repeat with 0x3000_0000.
